// File: rtl/proc_dmem_arb.sv
// proc_dmem_arb: shares one single-ported data memory among NREQ requesters.
// Handshake: a requester transfers in a cycle when req_val[i] && req_rdy[i];
// req_rdy is a combinational one-hot grant. Each accepted request produces a
// one-cycle resp_val[i] pulse exactly one cycle later, carrying the memory
// read data (writes get the same pulse as an acknowledge).
module proc_dmem_arb #(
    parameter int NREQ     = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ-1:0]      req_type,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      resp_val,
    output logic [DW-1:0]        resp_rdata,
    output logic                 mem_req_val,
    output logic                 mem_req_type,
    output logic [AW-1:0]        mem_req_addr,
    output logic [DW-1:0]        mem_req_wdata,
    input  logic [DW-1:0]        mem_resp_rdata,
    output logic [15:0]          cnt_grant,
    output logic [15:0]          cnt_conflict
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Pointer only moves in round-robin mode with more than one requester.
    localparam bit RR = (ARB_MODE == 0) && (NREQ > 1);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] rsp_q, rsp_d;
    logic [15:0]     cnt_grant_q, cnt_grant_d;
    logic [15:0]     cnt_conflict_q, cnt_conflict_d;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            conflict;

    // Grant search: first valid requester from ptr upward with wrap; reset masks all grants.
    always_comb begin : grant_search
        int   base;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        base    = RR ? int'(ptr_q) : 0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && rst && req_val[i] && (i == ((base + k) % NREQ))) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = PW'(i);
                end
            end
        end
    end

    // Request path: route the granted requester's fields onto the memory port.
    always_comb begin
        mem_req_type  = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_req_type  = req_type[i];
                mem_req_addr  = req_addr[i*AW +: AW];
                mem_req_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Conflict detection: two or more requesters asserting valid this cycle.
    always_comb begin : conflict_count
        int n;
        n = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_val[i]) n = n + 1;
        end
        conflict = (n >= 2);
    end

    // Next-state: pointer advance past the winner, response tracking, saturating counters.
    always_comb begin
        ptr_d = ptr_q;
        if (RR && mem_req_val) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        rsp_d          = gnt;
        cnt_grant_d    = cnt_grant_q;
        cnt_conflict_d = cnt_conflict_q;
        if (mem_req_val && (cnt_grant_q != 16'hFFFF)) begin
            cnt_grant_d = cnt_grant_q + 16'd1;
        end
        if (conflict && (cnt_conflict_q != 16'hFFFF)) begin
            cnt_conflict_d = cnt_conflict_q + 16'd1;
        end
    end

    // State registers; reset discards any in-flight response and restarts at ptr 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q          <= '0;
            rsp_q          <= '0;
            cnt_grant_q    <= '0;
            cnt_conflict_q <= '0;
        end else begin
            ptr_q          <= ptr_d;
            rsp_q          <= rsp_d;
            cnt_grant_q    <= cnt_grant_d;
            cnt_conflict_q <= cnt_conflict_d;
        end
    end

    assign req_rdy      = gnt;
    assign mem_req_val  = |gnt;
    assign resp_val     = rsp_q;
    assign resp_rdata   = (|rsp_q) ? mem_resp_rdata : '0;
    assign cnt_grant    = cnt_grant_q;
    assign cnt_conflict = cnt_conflict_q;

endmodule

// File: tb/tb_proc_dmem_arb.sv
// Directed bench for proc_dmem_arb: 2-requester round-robin with a write-first
// memory model, 4-requester round-robin, and 2-requester fixed priority.
module tb_proc_dmem_arb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- NREQ=2 round-robin instance ----------------
    logic [1:0]  r2_val, r2_rdy, r2_type, r2_rsp;
    logic [63:0] r2_addr, r2_wdata;
    logic [31:0] r2_rdata, m2_addr, m2_wdata, m2_rdata;
    logic        m2_val, m2_type;
    logic [15:0] r2_cg, r2_cc;

    proc_dmem_arb #(.NREQ(2), .AW(32), .DW(32), .ARB_MODE(0)) u2 (
        .clk(clk), .rst(rst),
        .req_val(r2_val), .req_rdy(r2_rdy), .req_type(r2_type),
        .req_addr(r2_addr), .req_wdata(r2_wdata),
        .resp_val(r2_rsp), .resp_rdata(r2_rdata),
        .mem_req_val(m2_val), .mem_req_type(m2_type),
        .mem_req_addr(m2_addr), .mem_req_wdata(m2_wdata),
        .mem_resp_rdata(m2_rdata),
        .cnt_grant(r2_cg), .cnt_conflict(r2_cc)
    );

    // Write-first single-port memory, read data one cycle after the request.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (m2_val) begin
            if (m2_type) begin
                mem[m2_addr[9:2]] <= m2_wdata;
                m2_rdata          <= m2_wdata;
            end else begin
                m2_rdata <= mem[m2_addr[9:2]];
            end
        end
    end

    // ---------------- NREQ=4 round-robin instance ----------------
    logic [3:0]   r4_val, r4_rdy, r4_type, r4_rsp;
    logic [127:0] r4_addr, r4_wdata;
    logic [31:0]  r4_rdata, m4_addr, m4_wdata;
    logic         m4_val, m4_type;
    logic [15:0]  r4_cg, r4_cc;
    logic [31:0]  zero32 = 32'h0;

    proc_dmem_arb #(.NREQ(4), .AW(32), .DW(32), .ARB_MODE(0)) u4 (
        .clk(clk), .rst(rst),
        .req_val(r4_val), .req_rdy(r4_rdy), .req_type(r4_type),
        .req_addr(r4_addr), .req_wdata(r4_wdata),
        .resp_val(r4_rsp), .resp_rdata(r4_rdata),
        .mem_req_val(m4_val), .mem_req_type(m4_type),
        .mem_req_addr(m4_addr), .mem_req_wdata(m4_wdata),
        .mem_resp_rdata(zero32),
        .cnt_grant(r4_cg), .cnt_conflict(r4_cc)
    );

    // ---------------- NREQ=2 fixed-priority instance ----------------
    logic [1:0]  rf_val, rf_rdy, rf_type, rf_rsp;
    logic [63:0] rf_addr, rf_wdata;
    logic [31:0] rf_rdata, mf_addr, mf_wdata;
    logic        mf_val, mf_type;
    logic [15:0] rf_cg, rf_cc;

    proc_dmem_arb #(.NREQ(2), .AW(32), .DW(32), .ARB_MODE(1)) uf (
        .clk(clk), .rst(rst),
        .req_val(rf_val), .req_rdy(rf_rdy), .req_type(rf_type),
        .req_addr(rf_addr), .req_wdata(rf_wdata),
        .resp_val(rf_rsp), .resp_rdata(rf_rdata),
        .mem_req_val(mf_val), .mem_req_type(mf_type),
        .mem_req_addr(mf_addr), .mem_req_wdata(mf_wdata),
        .mem_resp_rdata(zero32),
        .cnt_grant(rf_cg), .cnt_conflict(rf_cc)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; checks follow 2 time units later.
    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] rr2_exp [3];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        m2_rdata = 32'h0;
        r2_val = '0; r2_type = '0; r2_addr = '0; r2_wdata = '0;
        r4_val = '0; r4_type = '0; r4_addr = '0; r4_wdata = '0;
        rf_val = '0; rf_type = '0; rf_addr = '0; rf_wdata = '0;
        for (int i = 0; i < 4; i++) r4_addr[i*32 +: 32] = 32'h1000 + i;

        // Reset with both requesters asking: everything forced quiet.
        rst = 1'b0; r2_val = 2'b11;
        tick(); tick(); #2;
        chk("rst_rdy", {30'b0, r2_rdy}, 32'h0);
        chk("rst_mval", {31'b0, m2_val}, 32'h0);
        chk("rst_rsp", {30'b0, r2_rsp}, 32'h0);
        chk("rst_rdata", r2_rdata, 32'h0);
        chk("rst_cg", {16'b0, r2_cg}, 32'h0);
        chk("rst_cc", {16'b0, r2_cc}, 32'h0);

        // Release: first cycle grants requester 0.
        tick(); rst = 1'b1; #2;
        chk("rel_rdy", {30'b0, r2_rdy}, 32'h1);
        chk("rel_mval", {31'b0, m2_val}, 32'h1);
        tick(); r2_val = 2'b00; #2;
        chk("rel_rsp", {30'b0, r2_rsp}, 32'h1);
        chk("rel_cg", {16'b0, r2_cg}, 32'h1);
        chk("rel_cc", {16'b0, r2_cc}, 32'h1);

        // Requester 1: write 0xDEADBEEF to 0x100, then read it back.
        tick(); r2_val = 2'b10; r2_type = 2'b10;
        r2_addr = {32'h100, 32'h0}; r2_wdata = {32'hDEADBEEF, 32'h0}; #2;
        chk("wr_rdy", {30'b0, r2_rdy}, 32'h2);
        chk("wr_type", {31'b0, m2_type}, 32'h1);
        chk("wr_addr", m2_addr, 32'h100);
        chk("wr_wdata", m2_wdata, 32'hDEADBEEF);
        tick(); r2_type = 2'b00; #2;
        chk("wr_ack", {30'b0, r2_rsp}, 32'h2);
        chk("rd_rdy", {30'b0, r2_rdy}, 32'h2);
        chk("rd_type", {31'b0, m2_type}, 32'h0);
        tick(); r2_val = 2'b00; #2;
        chk("rd_rsp", {30'b0, r2_rsp}, 32'h2);
        chk("rd_data", r2_rdata, 32'hDEADBEEF);
        tick(); #2;
        chk("idle_rsp", {30'b0, r2_rsp}, 32'h0);
        chk("idle_rdata", r2_rdata, 32'h0);

        // Back-to-back: req0 writes 0x5 to 0x40, req1 reads 0x40 next cycle.
        tick(); r2_val = 2'b01; r2_type = 2'b01;
        r2_addr = {32'h0, 32'h40}; r2_wdata = {32'h0, 32'h5}; #2;
        chk("b2b_rdy0", {30'b0, r2_rdy}, 32'h1);
        tick(); r2_val = 2'b10; r2_type = 2'b00; r2_addr = {32'h40, 32'h40}; #2;
        chk("b2b_rsp0", {30'b0, r2_rsp}, 32'h1);
        chk("b2b_rdy1", {30'b0, r2_rdy}, 32'h2);
        tick(); r2_val = 2'b00; #2;
        chk("b2b_rsp1", {30'b0, r2_rsp}, 32'h2);
        chk("b2b_data", r2_rdata, 32'h5);

        // Two-requester round-robin alternation from ptr=0.
        rr2_exp[0] = 2'b01; rr2_exp[1] = 2'b10; rr2_exp[2] = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick(); r2_val = 2'b11; r2_type = 2'b00; #2;
            chk("rr2_rdy", {30'b0, r2_rdy}, {30'b0, rr2_exp[k]});
        end

        // Reset mid-flight: read granted, reset in the response cycle.
        tick(); r2_val = 2'b01; #2;
        chk("mf_rdy", {30'b0, r2_rdy}, 32'h1);
        tick(); r2_val = 2'b00; #2;
        chk("mf_pre_rsp", {30'b0, r2_rsp}, 32'h1);
        rst = 1'b0; #1;
        chk("mf_rsp_clr", {30'b0, r2_rsp}, 32'h0);
        chk("mf_cg", {16'b0, r2_cg}, 32'h0);
        chk("mf_cc", {16'b0, r2_cc}, 32'h0);
        tick(); tick(); rst = 1'b1; r2_val = 2'b11; #2;
        chk("mf_post_rsp", {30'b0, r2_rsp}, 32'h0);
        chk("mf_fresh_rdy", {30'b0, r2_rdy}, 32'h1);
        tick(); r2_val = 2'b00; #2;
        chk("mf_new_rsp", {30'b0, r2_rsp}, 32'h1);

        // Four-requester round-robin: order 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            tick(); r4_val = 4'hF; #2;
            chk("rr4_rdy", {28'b0, r4_rdy}, 32'h1 << (k % 4));
            chk("rr4_addr", m4_addr, 32'h1000 + (k % 4));
        end
        tick(); r4_val = 4'h0; #2;
        chk("rr4_cg", {16'b0, r4_cg}, 32'd8);
        chk("rr4_cc", {16'b0, r4_cc}, 32'd8);

        // Fixed priority: requester 0 always wins.
        for (int k = 0; k < 3; k++) begin
            tick(); rf_val = 2'b11; #2;
            chk("fp_rdy", {30'b0, rf_rdy}, 32'h1);
        end
        tick(); rf_val = 2'b10; #2;
        chk("fp_only1", {30'b0, rf_rdy}, 32'h2);
        tick(); rf_val = 2'b00;

        // Counter saturation: 65540 contended grants.
        tick(); r2_val = 2'b11; r2_type = 2'b00;
        repeat (65540) tick();
        r2_val = 2'b00; #2;
        chk("sat_cg", {16'b0, r2_cg}, 32'hFFFF);
        chk("sat_cc", {16'b0, r2_cc}, 32'hFFFF);
        tick(); #2;
        chk("sat_hold", {16'b0, r2_cg}, 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
